// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: issues enabled, non-empty descriptors in index order to the rd/wr streamers.
// Latency: go -> first start 2 cycles; per-descriptor completion -> next start 2 cycles.
// Backpressure: each start holds until its own ready is sampled; completion waits for both done pulses.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   go_i, abort_i              CSR run control levels
//   desc_en_i, desc_bytes_i    per-descriptor enable and byte count (desc k at [k*BYTES_W+:BYTES_W])
//   rd_*/wr_*                  start/ready handshake and done pulse per streamer
//   desc_idx_o                 descriptor currently issued/served
//   pend_txn_i, axi_err_i      AXI outstanding-transaction level and error pulse
//   active_o, done_o           run status
//   aborted_o, err_o           sticky run-end causes, cleared on next go
//   desc_done_o                per-descriptor completed mask
//   clear_o                    1-cycle pulse on DONE->IDLE
module dma_desc_sched #(
   parameter int NUM_DESC = 2,
   parameter int BYTES_W  = 32,
   localparam int IDX_W   = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go_i,
   input  logic                        abort_i,
   input  logic [NUM_DESC-1:0]         desc_en_i,
   input  logic [NUM_DESC*BYTES_W-1:0] desc_bytes_i,
   output logic                        rd_start_o,
   input  logic                        rd_ready_i,
   input  logic                        rd_done_i,
   output logic                        wr_start_o,
   input  logic                        wr_ready_i,
   input  logic                        wr_done_i,
   output logic [IDX_W-1:0]            desc_idx_o,
   input  logic                        pend_txn_i,
   input  logic                        axi_err_i,
   output logic                        active_o,
   output logic                        done_o,
   output logic                        aborted_o,
   output logic                        err_o,
   output logic [NUM_DESC-1:0]         desc_done_o,
   output logic                        clear_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_DESC-1:0] pend_q, pend_d;
   logic [NUM_DESC-1:0] ddone_q, ddone_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                rd_start_q, rd_start_d;
   logic                wr_start_q, wr_start_d;
   logic                rd_flag_q, rd_flag_d;
   logic                wr_flag_q, wr_flag_d;
   logic                aborted_q, aborted_d;
   logic                err_q, err_d;
   logic                clear_q, clear_d;

   logic [NUM_DESC-1:0] go_mask;
   logic [IDX_W-1:0]    sel_idx;
   logic [IDX_W-1:0]    next_ptr;
   logic                sel_found;
   logic                in_run;

   // Descriptors worth running: enabled and carrying a non-zero byte count.
   always_comb begin
      go_mask = '0;
      for (int k = 0; k < NUM_DESC; k++) begin
         go_mask[k] = desc_en_i[k] && (desc_bytes_i[k*BYTES_W +: BYTES_W] != '0);
      end
   end

   // Round-robin search: first pending descriptor at or above ptr, wrapping.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < NUM_DESC; i++) begin
         int k;
         k = int'(ptr_q) + i;
         if (k >= NUM_DESC) k = k - NUM_DESC;
         if (!sel_found && pend_q[IDX_W'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(k);
         end
      end
   end

   assign next_ptr = (idx_q == IDX_W'(NUM_DESC - 1)) ? '0 : idx_q + 1'b1;
   assign in_run   = (state_q == S_SELECT) || (state_q == S_ISSUE) || (state_q == S_WAIT);

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      ddone_d    = ddone_q;
      ptr_d      = ptr_q;
      idx_d      = idx_q;
      rd_start_d = rd_start_q;
      wr_start_d = wr_start_q;
      rd_flag_d  = rd_flag_q;
      wr_flag_d  = wr_flag_q;
      aborted_d  = aborted_q;
      err_d      = err_q;
      clear_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (go_i) begin
               pend_d    = go_mask;
               ddone_d   = '0;
               aborted_d = 1'b0;
               err_d     = 1'b0;
               ptr_d     = '0;
               state_d   = (go_mask == '0) ? S_DONE : S_SELECT;
            end
         end
         S_SELECT: begin
            idx_d      = sel_idx;
            rd_start_d = 1'b1;
            wr_start_d = 1'b1;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            if (rd_ready_i) rd_start_d = 1'b0;
            if (wr_ready_i) wr_start_d = 1'b0;
            // Fast streamers may finish before the other side has even accepted.
            if (rd_done_i)  rd_flag_d  = 1'b1;
            if (wr_done_i)  wr_flag_d  = 1'b1;
            if (!rd_start_d && !wr_start_d) state_d = S_WAIT;
         end
         S_WAIT: begin
            rd_flag_d = rd_flag_q | rd_done_i;
            wr_flag_d = wr_flag_q | wr_done_i;
            if (rd_flag_d && wr_flag_d) begin
               pend_d[idx_q]  = 1'b0;
               ddone_d[idx_q] = 1'b1;
               ptr_d          = next_ptr;
               rd_flag_d      = 1'b0;
               wr_flag_d      = 1'b0;
               state_d        = (pend_d == '0) ? S_DRAIN : S_SELECT;
            end
         end
         S_DRAIN: begin
            if (axi_err_i)   err_d   = 1'b1;
            if (!pend_txn_i) state_d = S_DONE;
         end
         S_DONE: begin
            if (!go_i) begin
               state_d = S_IDLE;
               clear_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort or AXI error overrides any progress made this cycle, including a
      // completion landing in the same WAIT cycle.
      if (in_run && (abort_i || axi_err_i)) begin
         state_d    = S_DRAIN;
         pend_d     = pend_q;
         ddone_d    = ddone_q;
         ptr_d      = ptr_q;
         rd_start_d = 1'b0;
         wr_start_d = 1'b0;
         rd_flag_d  = 1'b0;
         wr_flag_d  = 1'b0;
         aborted_d  = aborted_q | abort_i;
         err_d      = err_q | axi_err_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pend_q     <= '0;
         ddone_q    <= '0;
         ptr_q      <= '0;
         idx_q      <= '0;
         rd_start_q <= 1'b0;
         wr_start_q <= 1'b0;
         rd_flag_q  <= 1'b0;
         wr_flag_q  <= 1'b0;
         aborted_q  <= 1'b0;
         err_q      <= 1'b0;
         clear_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ddone_q    <= ddone_d;
         ptr_q      <= ptr_d;
         idx_q      <= idx_d;
         rd_start_q <= rd_start_d;
         wr_start_q <= wr_start_d;
         rd_flag_q  <= rd_flag_d;
         wr_flag_q  <= wr_flag_d;
         aborted_q  <= aborted_d;
         err_q      <= err_d;
         clear_q    <= clear_d;
      end
   end

   assign rd_start_o  = rd_start_q;
   assign wr_start_o  = wr_start_q;
   assign desc_idx_o  = idx_q;
   assign active_o    = in_run || (state_q == S_DRAIN);
   assign done_o      = (state_q == S_DONE);
   assign aborted_o   = aborted_q;
   assign err_o       = err_q;
   assign desc_done_o = ddone_q;
   assign clear_o     = clear_q;

endmodule
